// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver behind a 2-flop rx synchronizer; even parity check under `UART_RX_PARITY_EN.
// o_rx_done pulses one cycle after the stop-bit sample; no backpressure, o_data/o_frame_err hold until the next frame.
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_rx_done,
  output logic               o_frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic               o_parity_err
`endif
);

  localparam int NB_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]         state;
  logic [3:0]         s;
  logic [NB_W-1:0]    n;
  logic [NB_DATA-1:0] shift;
  logic               rx_meta;
  logic               rx_sync;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
`endif

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      s           <= 4'd0;
      n           <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_rx_done <= 1'b0;
      case (state)
        // Start detection does not wait for a tick so the half-bit count begins immediately.
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            s     <= 4'd0;
          end
        end
        START: begin
          if (i_tick) begin
            if (s == 4'd7) begin
              if (!rx_sync) begin
                state <= DATA;
                s     <= 4'd0;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (s == 4'd15) begin
              s     <= 4'd0;
              shift <= {rx_sync, shift[NB_DATA-1:1]};
              if (n == NB_W'(NB_DATA - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (i_tick) begin
            if (s == 4'd15) begin
              s       <= 4'd0;
              par_bit <= rx_sync;
              state   <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
`endif
        STOP: begin
          if (i_tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              o_data      <= shift;
              o_frame_err <= ~rx_sync;
              o_rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
              o_parity_err <= (^shift) ^ par_bit;
`endif
              state       <= IDLE;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

  logic       i_clk   = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick  = 1'b0;
  logic       i_rx    = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_done;
  logic       o_frame_err;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  // Frames reported by the DUT, captured on each o_rx_done pulse.
  logic [7:0] got_data[$];
  logic       got_ferr[$];
  logic       got_perr[$];
  int         pulse_err = 0;
  int         stab_err  = 0;

  logic [7:0] exp_last_data;

  uart_rx #(.NB_DATA(8), .SB_TICK(16)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  initial forever #5 i_clk = ~i_clk;

  // One-cycle tick every 4th clock: one bit time is 16 ticks = 64 clocks.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge i_clk);
      tc++;
      i_tick = (tc % 4 == 0);
    end
  end

  initial begin
    logic       pd;
    logic [7:0] pdat;
    logic       pf;
    pd = 1'b0; pdat = 8'h00; pf = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        if (o_rx_done) begin
          got_data.push_back(o_data);
          got_ferr.push_back(o_frame_err);
`ifdef UART_RX_PARITY_EN
          got_perr.push_back(o_parity_err);
`else
          got_perr.push_back(1'b0);
`endif
          if (pd) pulse_err++;
        end else if (o_data !== pdat || o_frame_err !== pf) begin
          stab_err++;
        end
      end
      pd = o_rx_done; pdat = o_data; pf = o_frame_err;
    end
  end

  task automatic drive(input logic v, input int cyc);
    i_rx = v;
    repeat (cyc) @(negedge i_clk);
  endtask

  // Low stop bits are cut short and followed by a long idle so the trailing
  // low level can only produce a false start, never a phantom frame.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int idle);
    int idl;
    idl = idle;
    drive(1'b0, 64);
    for (int i = 0; i < 8; i++) drive(d[i], 64);
`ifdef UART_RX_PARITY_EN
    drive(par, 64);
`else
    if (par === 1'bx) drive(1'b1, 0);
`endif
    if (stop) begin
      drive(1'b1, 64);
    end else begin
      drive(1'b0, 48);
      if (idl < 96) idl = 96;
    end
    if (idl > 0) drive(1'b1, idl);
  endtask

  task automatic test_reset;
    repeat (5) @(negedge i_clk);
    checks++;
    if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", o_data); end
    checks++;
    if (o_rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_rx_done); end
    checks++;
    if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", o_frame_err); end
    #2 i_reset = 1'b1;
    repeat (10) @(negedge i_clk);
    exp_last_data = 8'h00;
  endtask

  task automatic test_basic;
    int n0;
    n0 = got_data.size();
    send_frame(8'hA5, ^8'hA5, 1'b1, 100);
    checks++;
    if (got_data.size() != n0 + 1) begin
      errors++; $display("FAIL basic_count: got %0d frames want 1", got_data.size() - n0);
    end else begin
      checks++;
      if (got_data[n0] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_data[n0]); end
      checks++;
      if (got_ferr[n0] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b want 0", got_ferr[n0]); end
    end
    exp_last_data = 8'hA5;
  endtask

  task automatic test_false_start;
    int n0;
    n0 = got_data.size();
    drive(1'b0, 12);
    drive(1'b1, 200);
    checks++;
    if (got_data.size() != n0) begin errors++; $display("FAIL glitch_count: got %0d frames want 0", got_data.size() - n0); end
    checks++;
    if (o_data !== exp_last_data) begin errors++; $display("FAIL glitch_data: got %h want %h", o_data, exp_last_data); end
  endtask

  task automatic test_frame_error;
    int n0;
    n0 = got_data.size();
    send_frame(8'h3C, ^8'h3C, 1'b0, 100);
    checks++;
    if (o_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b want 1", o_frame_err); end
    send_frame(8'h01, ^8'h01, 1'b1, 100);
    checks++;
    if (got_data.size() != n0 + 2) begin
      errors++; $display("FAIL ferr_count: got %0d frames want 2", got_data.size() - n0);
    end else begin
      checks++;
      if (got_data[n0] !== 8'h3C || got_ferr[n0] !== 1'b1) begin
        errors++; $display("FAIL ferr_bad: got %h/%b want 3c/1", got_data[n0], got_ferr[n0]);
      end
      checks++;
      if (got_data[n0+1] !== 8'h01 || got_ferr[n0+1] !== 1'b0) begin
        errors++; $display("FAIL ferr_good: got %h/%b want 01/0", got_data[n0+1], got_ferr[n0+1]);
      end
    end
    exp_last_data = 8'h01;
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = got_data.size();
    send_frame(8'h55, ^8'h55, 1'b1, 0);
    send_frame(8'hAA, ^8'hAA, 1'b1, 100);
    checks++;
    if (got_data.size() != n0 + 2) begin
      errors++; $display("FAIL b2b_count: got %0d frames want 2", got_data.size() - n0);
    end else begin
      checks++;
      if (got_data[n0] !== 8'h55) begin errors++; $display("FAIL b2b_first: got %h want 55", got_data[n0]); end
      checks++;
      if (got_data[n0+1] !== 8'hAA) begin errors++; $display("FAIL b2b_second: got %h want aa", got_data[n0+1]); end
    end
    exp_last_data = 8'hAA;
  endtask

  task automatic test_reset_midframe;
    int n0;
    n0 = got_data.size();
    drive(1'b0, 64);
    for (int i = 0; i < 4; i++) drive(1'b1, 64);
    #2 i_reset = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_data !== 8'h00 || o_rx_done !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h/%b/%b want 00/0/0", o_data, o_rx_done, o_frame_err);
    end
    repeat (20) @(negedge i_clk);
    #2 i_reset = 1'b1;
    drive(1'b1, 100);
    send_frame(8'h12, ^8'h12, 1'b1, 100);
    checks++;
    if (got_data.size() != n0 + 1) begin
      errors++; $display("FAIL midreset_count: got %0d frames want 1", got_data.size() - n0);
    end else begin
      checks++;
      if (got_data[n0] !== 8'h12 || got_ferr[n0] !== 1'b0) begin
        errors++; $display("FAIL midreset_data: got %h/%b want 12/0", got_data[n0], got_ferr[n0]);
      end
    end
    exp_last_data = 8'h12;
  endtask

  task automatic test_random;
    int         n0;
    logic [7:0] ed[$];
    logic       ef[$];
    logic       ep[$];
    n0 = got_data.size();
    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      logic       stop;
      logic       par;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ 1'($urandom_range(0, 1));
      ed.push_back(d);
      ef.push_back(~stop);
      ep.push_back((^d) ^ par);
      send_frame(d, par, stop, $urandom_range(0, 80));
    end
    drive(1'b1, 200);
    checks++;
    if (got_data.size() != n0 + 20) begin
      errors++; $display("FAIL rand_count: got %0d frames want 20", got_data.size() - n0);
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (got_data[n0+k] !== ed[k] || got_ferr[n0+k] !== ef[k]) begin
          errors++; $display("FAIL rand_frame%0d: got %h/%b want %h/%b", k, got_data[n0+k], got_ferr[n0+k], ed[k], ef[k]);
        end
`ifdef UART_RX_PARITY_EN
        checks++;
        if (got_perr[n0+k] !== ep[k]) begin
          errors++; $display("FAIL rand_parity%0d: got %b want %b", k, got_perr[n0+k], ep[k]);
        end
`endif
      end
      exp_last_data = ed[19];
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0;
    n0 = got_data.size();
    send_frame(8'h07, 1'b1, 1'b1, 100);
    send_frame(8'h07, 1'b0, 1'b1, 100);
    checks++;
    if (got_data.size() != n0 + 2) begin
      errors++; $display("FAIL parity_count: got %0d frames want 2", got_data.size() - n0);
    end else begin
      checks++;
      if (got_perr[n0] !== 1'b0) begin errors++; $display("FAIL parity_good: got %b want 0", got_perr[n0]); end
      checks++;
      if (got_perr[n0+1] !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b want 1", got_perr[n0+1]); end
    end
  endtask
`endif

  task automatic test_stability;
    checks++;
    if (pulse_err != 0) begin errors++; $display("FAIL done_width: got %0d long pulses want 0", pulse_err); end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL output_stable: got %0d changes want 0", stab_err); end
  endtask

  initial begin
    @(negedge i_clk);
    test_reset;
    test_basic;
    test_false_start;
    test_frame_error;
    test_back_to_back;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    test_random;
    test_stability;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
